seg7_scan_4dig: RTL and testbench
=================================

# seg7_scan_4dig

Four-digit multiplexed 7-segment display driver. It sits directly downstream of the board's BCD counters and takes four packed BCD digits, such as a 0–9 counter output per digit. It time-multiplexes them onto one shared active-low segment bus with per-digit active-low anode enables. New values are double-buffered and committed only at frame boundaries, so a scan frame never shows a mix of old and new digits.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range 2..2^20; counter width `$clog2(REFRESH_DIV)`.
- `clk`  in  1: system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `bcd`  in  16: four BCD digits; `[3:0]` is digit 0 (rightmost, `an[0]`), `[15:12]` is digit 3.
- `dp_in`  in  4: decimal point per digit, active-high; bit i belongs to digit i.
- `load`  in  1: one-cycle strobe; captures `bcd`/`dp_in` into the pending buffer.
- `seg`  out  7: `{g,f,e,d,c,b,a}`, active-low, registered.
- `dp`  out  1: decimal point, active-low, registered.
- `an`  out  4: digit enables, active-low, one-hot-zero, registered.
- `frame_done`  out  1: one-cycle pulse at each frame boundary.

## Operation
- Refresh counter `rc` counts 0..REFRESH_DIV-1 and wraps to 0.
  - A digit tick occurs on the edge where `rc == REFRESH_DIV-1`.
- Digit index `idx` (2 bits) advances on each tick, 3→0 wrapping. The 3→0 advance is the frame boundary.
- Buffering:
  - `load` writes the pending register and sets `pend_v`. If `pend_v` is already set, the new value overwrites it (latest wins).
  - At a frame boundary with `pend_v` = 1, the display register takes the pending value and `pend_v` clears.
  - A `load` asserted in the same cycle as a boundary lands in pending and is committed at the next boundary.
- On every tick, `an`, `seg` and `dp` update on the same edge and always describe the same digit. At a boundary they reflect the newly committed display value.
- Decode, as active-low hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes 10–15 show a dash, 3F.
  - Blank is 7F.
- `dp` = ~dp_in bit of the displayed digit, taken from the display register.

## Timing
- Reset values:
  - `rc`=0, `idx`=3.
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_done`=0.
  - Display register = 0, `pend_v`=0.
- The first tick comes REFRESH_DIV cycles after reset deasserts. It is a frame boundary: `an`=4'b1110, `frame_done` pulses.
- After that, each digit is lit for exactly REFRESH_DIV cycles, and a frame is 4·REFRESH_DIV cycles.
- Reset asserted mid-frame returns everything to reset values on the next edge. Any pending value is discarded.
- Latency: a `load` is visible at most 4·REFRESH_DIV cycles later, at the first boundary strictly after the load cycle.
- `frame_done` is high only for the single cycle following the boundary edge.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking is enabled.
  - Digit i (i = 3, 2, 1) shows 7F when it and every higher digit equal 0.
  - Digit 0 is never blanked.
  - Codes 10–15 count as non-zero.
  - `dp` is unaffected by blanking.
- `SEG7_LZB_EN` undefined: all four digits are always decoded, including leading zeros.

## Test plan
Benches use REFRESH_DIV=4.
- Reset, then idle → `an`=1111 and `seg`=7F for cycles 1–3. At the 4th edge, `an`=1110, `seg`=40, `frame_done`=1 for 1 cycle.
- `load` with bcd=16'h1234, dp_in=4'b0100 mid-frame → the frame in progress is unchanged. Next frame shows digit0=19, digit1=30, digit2=24 with `dp`=0, digit3=79.
- Two `load`s (16'h1111, then 16'h5678) within one frame → only 5678 appears; 1111 is never displayed.
- `load` 16'h00A0 → digit1 shows 3F. With `SEG7_LZB_EN`, digits 3 and 2 show 7F. Without it, they show 40.
- `load` coincident with the boundary edge → the old value is shown for that frame, and the new value appears at the following boundary.
- Reset asserted mid-digit with `pend_v`=1 → reset values on the next edge; after restart the display shows 0000, not the pending value.

Source files
------------

// File: rtl/seg7_scan_4dig.sv
// Four-digit multiplexed 7-segment driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_4dig #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] RC_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] rc;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic          tick;
  logic          boundary;
  logic          commit;

  logic [15:0]   pend_bcd;
  logic [3:0]    pend_dp;
  logic          pend_v;
  logic [15:0]   disp_bcd;
  logic [3:0]    disp_dp;
  logic [15:0]   next_bcd;
  logic [3:0]    next_dp;

  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_code;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] code;
    case (v)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h3F;
    endcase
    return code;
  endfunction

  // The digit about to be lit is decoded from the value the display register
  // will hold after this edge, so a boundary shows the newly committed frame.
  always_comb begin
    tick     = (rc == RC_LAST);
    boundary = tick && (idx == 2'd3);
    next_idx = idx + 2'd1;
    commit   = boundary && pend_v;
    next_bcd = commit ? pend_bcd : disp_bcd;
    next_dp  = commit ? pend_dp  : disp_dp;
    digit    = next_bcd[{next_idx, 2'b00} +: 4];
  end

  always_comb begin
    blank = 1'b0;
`ifdef SEG7_LZB_EN
    case (next_idx)
      2'd3:    blank = (next_bcd[15:12] == 4'd0);
      2'd2:    blank = (next_bcd[15:8]  == 8'd0);
      2'd1:    blank = (next_bcd[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
    seg_code = blank ? 7'h7F : decode(digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rc  <= '0;
      idx <= 2'd3;
    end else if (tick) begin
      rc  <= '0;
      idx <= next_idx;
    end else begin
      rc  <= rc + 1'b1;
    end
  end

  // A load coincident with a commit lands in pending and stays valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_bcd <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
      disp_bcd <= '0;
      disp_dp  <= '0;
    end else begin
      if (commit) begin
        disp_bcd <= pend_bcd;
        disp_dp  <= pend_dp;
        pend_v   <= 1'b0;
      end
      if (load) begin
        pend_bcd <= bcd;
        pend_dp  <= dp_in;
        pend_v   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        an  <= ~(4'b0001 << next_idx);
        seg <= seg_code;
        dp  <= ~next_dp[next_idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_4dig.sv
// Self-checking bench for seg7_scan_4dig: directed test-plan steps plus random
// loads, compared each cycle against a frame-level reference model.
module tb_seg7_scan_4dig;

  localparam int R = 4;
  localparam int FRAME = 4 * R;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] bcd;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  int          n;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic [3:0]  m_disp_dp;
  logic [3:0]  m_pend_dp;
  bit          m_pend_v;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;
  logic [6:0]  lut [16];

  seg7_scan_4dig #(.REFRESH_DIV(R)) dut (
    .clk(clk),
    .reset(reset),
    .bcd(bcd),
    .dp_in(dp_in),
    .load(load),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: n counts edges since reset; every R-th edge lights digit (n/R-1) mod 4.
  task automatic model_edge();
    int d;
    bit t;
    if (reset) begin
      n = 0;
      m_disp = '0;
      m_disp_dp = '0;
      m_pend_v = 0;
      e_an = 4'b1111;
      e_seg = 7'h7F;
      e_dp = 1'b1;
      e_fd = 1'b0;
    end else begin
      n++;
      e_fd = 1'b0;
      t = (n % R == 0);
      d = t ? ((n / R - 1) % 4) : 0;
      if (t && d == 0) begin
        e_fd = 1'b1;
        if (m_pend_v) begin
          m_disp = m_pend;
          m_disp_dp = m_pend_dp;
          m_pend_v = 0;
        end
      end
      if (load) begin
        m_pend = bcd;
        m_pend_dp = dp_in;
        m_pend_v = 1;
      end
      if (t) begin
        e_an = 4'b1111;
        e_an[d] = 1'b0;
        e_seg = lut[m_disp[4*d +: 4]];
`ifdef SEG7_LZB_EN
        if (d > 0 && (m_disp >> (4 * d)) == 16'd0) e_seg = 7'h7F;
`endif
        e_dp = ~m_disp_dp[d];
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, "/an"}, 16'(an), 16'(e_an));
    check({tag, "/seg"}, 16'(seg), 16'(e_seg));
    check({tag, "/dp"}, 16'(dp), 16'(e_dp));
    check({tag, "/frame_done"}, 16'(frame_done), 16'(e_fd));
  endtask

  task automatic apply_stimulus(input string tag, input logic r, input logic l,
                                input logic [15:0] b, input logic [3:0] d);
    @(negedge clk);
    reset = r;
    load  = l;
    bcd   = b;
    dp_in = d;
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  task automatic idle(input string tag, input int k);
    for (int i = 0; i < k; i++)
      apply_stimulus(tag, 1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Idle until the model's edge count satisfies n mod FRAME == target.
  task automatic run_to(input string tag, input int target);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (n % FRAME == target) break;
      idle(tag, 1);
    end
  endtask

  initial begin
    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    n = 0;
    m_pend = '0;
    m_pend_dp = '0;

    apply_stimulus("reset", 1'b1, 1'b0, 16'h9999, 4'hF);
    apply_stimulus("reset", 1'b1, 1'b0, 16'h9999, 4'hF);
    check("reset_an", 16'(an), 16'h000F);
    check("reset_seg", 16'(seg), 16'h007F);
    check("reset_dp", 16'(dp), 16'h0001);

    idle("startup", 3);
    check("pre_tick_an", 16'(an), 16'h000F);
    check("pre_tick_seg", 16'(seg), 16'h007F);
    idle("first_tick", 1);
    check("first_tick_an", 16'(an), 16'h000E);
    check("first_tick_seg", 16'(seg), 16'h0040);
    check("first_tick_fd", 16'(frame_done), 16'h0001);
    idle("after_tick", 1);
    check("fd_one_cycle", 16'(frame_done), 16'h0000);

    apply_stimulus("load_1234", 1'b0, 1'b1, 16'h1234, 4'b0100);
    run_to("frame_1234", 4);
    check("d0_1234_seg", 16'(seg), 16'h0019);
    check("d0_1234_an", 16'(an), 16'h000E);
    run_to("frame_1234", 12);
    check("d2_1234_seg", 16'(seg), 16'h0024);
    check("d2_1234_dp", 16'(dp), 16'h0000);
    check("d2_1234_an", 16'(an), 16'h000B);
    idle("frame_1234", 8);

    run_to("two_loads", 5);
    apply_stimulus("load_1111", 1'b0, 1'b1, 16'h1111, 4'b0000);
    apply_stimulus("load_5678", 1'b0, 1'b1, 16'h5678, 4'b0001);
    idle("latest_wins", 2 * FRAME);

    apply_stimulus("load_00A0", 1'b0, 1'b1, 16'h00A0, 4'b0000);
    run_to("dash", 8);
    idle("dash", 1);
    run_to("dash", 8);
    check("d1_dash_seg", 16'(seg), 16'h003F);
    idle("dash", FRAME);

    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((n + 1) % FRAME == 4) break;
      idle("to_boundary", 1);
    end
    apply_stimulus("load_at_boundary", 1'b0, 1'b1, 16'h9876, 4'b1000);
    check("boundary_old_seg", 16'(seg), 16'h0040);
    check("boundary_fd", 16'(frame_done), 16'h0001);
    idle("boundary_wait", 1);
    run_to("boundary_next", 4);
    check("boundary_new_seg", 16'(seg), 16'h0002);
    idle("boundary_frame", FRAME);

    run_to("pend_reset", 6);
    apply_stimulus("load_4321", 1'b0, 1'b1, 16'h4321, 4'b1111);
    idle("pend_reset", 2);
    apply_stimulus("mid_reset", 1'b1, 1'b0, 16'h0000, 4'h0);
    check("mid_reset_an", 16'(an), 16'h000F);
    check("mid_reset_seg", 16'(seg), 16'h007F);
    check("mid_reset_fd", 16'(frame_done), 16'h0000);
    idle("restart", R);
    check("restart_seg", 16'(seg), 16'h0040);
    check("restart_dp", 16'(dp), 16'h0001);
    idle("restart", 2 * FRAME);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus("random", ($urandom_range(0, 149) == 0),
                     ($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom));
    end
    idle("drain", 2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
